// File: rtl/dmem_responder.sv
// Data-memory responder for the kodd core M-stage port: word RAM plus an MMIO block
// with a host-drained transmit FIFO, status/level registers and a free-running cycle counter.
module dmem_responder #(
  parameter int          DEPTH      = 64,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  input  logic        host_rd_en,
  output logic [31:0] host_rd_data,
  output logic        host_empty,
  output logic        host_err
);

  localparam int          AW         = $clog2(DEPTH);
  localparam int          FW         = $clog2(FIFO_DEPTH);
  localparam logic [FW:0] FULL_COUNT = (FW+1)'(FIFO_DEPTH);
  localparam logic [FW:0] ZERO_COUNT = (FW+1)'(0);
  localparam logic [31:0] RAM_LIMIT  = 32'(DEPTH * 4);
  localparam logic [5:0]  OFF_TX     = 6'd0;
  localparam logic [5:0]  OFF_CYCLE  = 6'd1;
  localparam logic [5:0]  OFF_LEVEL  = 6'd2;
  localparam logic [5:0]  OFF_CLR    = 6'd3;

  logic [31:0]   ram_r  [DEPTH];
  logic [31:0]   fifo_r [FIFO_DEPTH];
  logic [FW-1:0] wr_ptr_r;
  logic [FW-1:0] rd_ptr_r;
  logic [FW:0]   count_r;
  logic          ovf_r;
  logic          err_r;
  logic [31:0]   cycle_r;

  logic          ram_hit_s;
  logic          mmio_hit_s;
  logic [5:0]    off_s;
  logic [AW-1:0] ram_idx_s;
  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  logic          push_ok_s;
  logic          ovf_set_s;
  logic          err_set_s;
  logic          clr_s;
  logic [31:0]   status_s;
  logic [31:0]   level_s;
  logic [31:0]   rd_s;

  // Address decode: byte lanes ignored, RAM at the bottom, MMIO in one 256-byte page
  always_comb begin
    ram_hit_s  = (ALUOutM < RAM_LIMIT);
    mmio_hit_s = (ALUOutM[31:8] == MMIO_BASE[31:8]);
    off_s      = ALUOutM[7:2];
    ram_idx_s  = ALUOutM[AW+1:2];
  end

  // FIFO flow control, sticky-flag events and status words
  always_comb begin
    full_s    = (count_r == FULL_COUNT);
    empty_s   = (count_r == ZERO_COUNT);
    push_s    = MemWriteM && mmio_hit_s && (off_s == OFF_TX);
    clr_s     = MemWriteM && mmio_hit_s && (off_s == OFF_CLR);
    pop_s     = host_rd_en && !empty_s;
    // A pop frees the slot the push lands in, so full plus pop still accepts
    push_ok_s = push_s && (!full_s || pop_s);
    ovf_set_s = push_s && full_s && !pop_s;
    err_set_s = MemWriteM && !ram_hit_s && !push_s && !clr_s;
    status_s  = {28'h0, err_r, ovf_r, full_s, empty_s};
    level_s   = {{(31-FW){1'b0}}, count_r};
  end

  // Zero-latency load path; unmapped addresses read as zero
  always_comb begin
    rd_s = 32'h0;
    if (ram_hit_s) begin
      rd_s = ram_r[ram_idx_s];
    end else if (mmio_hit_s) begin
      case (off_s)
        OFF_TX:    rd_s = status_s;
        OFF_CYCLE: rd_s = cycle_r;
        OFF_LEVEL: rd_s = level_s;
        OFF_CLR:   rd_s = 32'h0;
        default:   rd_s = 32'h0;
      endcase
    end else begin
      rd_s = 32'h0;
    end
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (MemWriteM && ram_hit_s && !reset) begin
      ram_r[ram_idx_s] <= WriteDataM;
    end
  end

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push_ok_s && !reset) begin
      fifo_r[wr_ptr_r] <= WriteDataM;
    end
  end

  // FIFO pointers, occupancy, sticky flags and cycle counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      ovf_r    <= 1'b0;
      err_r    <= 1'b0;
      cycle_r  <= 32'h0;
    end else begin
      cycle_r <= cycle_r + 32'h1;
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + FW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + FW'(1);
      end
      count_r <= count_r + (FW+1)'(push_ok_s) - (FW+1)'(pop_s);
      // Set events take priority over a clear in the same cycle
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (clr_s && WriteDataM[0]) begin
        ovf_r <= 1'b0;
      end
      if (err_set_s) begin
        err_r <= 1'b1;
      end else if (clr_s && WriteDataM[1]) begin
        err_r <= 1'b0;
      end
    end
  end

  assign ReadDataM    = rd_s;
  assign host_rd_data = empty_s ? 32'h0 : fifo_r[rd_ptr_r];
  assign host_empty   = empty_s;
  assign host_err     = err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder with hand-written sequences
// for counter wrap, write-while-reset and asynchronous reset mid-operation.
module tb_dmem_responder;

  localparam logic [31:0] MB  = 32'hFFFF_FF00;
  localparam logic [31:0] TX  = MB;
  localparam logic [31:0] CYC = MB + 32'h4;
  localparam logic [31:0] LVL = MB + 32'h8;
  localparam logic [31:0] CLR = MB + 32'hC;

  logic        clk;
  logic        reset;
  logic        MemWriteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        host_rd_en;
  logic [31:0] host_rd_data;
  logic        host_empty;
  logic        host_err;

  int passed;
  int total;
  logic [31:0] exp_cyc;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        pop;
    logic        chk;
    logic [31:0] exp_rd;
    logic        exp_empty;
    logic [31:0] exp_hrd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  dmem_responder dut (
    .clk          (clk),
    .reset        (reset),
    .MemWriteM    (MemWriteM),
    .ALUOutM      (ALUOutM),
    .WriteDataM   (WriteDataM),
    .ReadDataM    (ReadDataM),
    .host_rd_en   (host_rd_en),
    .host_rd_data (host_rd_data),
    .host_empty   (host_empty),
    .host_err     (host_err)
  );

  always #5 clk = ~clk;

  // Reference cycle count: posedges since reset was last released
  always @(posedge clk or posedge reset) begin
    if (reset) exp_cyc <= 32'h0;
    else       exp_cyc <= exp_cyc + 32'h1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d, input logic p);
    @(negedge clk);
    MemWriteM  = we;
    ALUOutM    = a;
    WriteDataM = d;
    host_rd_en = p;
    #1;
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic pop, input logic chk, input logic [31:0] exp_rd,
                              input logic exp_empty, input logic [31:0] exp_hrd, input logic exp_err);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.pop = pop; v.chk = chk;
    v.exp_rd = exp_rd; v.exp_empty = exp_empty; v.exp_hrd = exp_hrd; v.exp_err = exp_err;
    return v;
  endfunction

  initial begin
    passed = 0; total = 0;
    clk = 1'b0; reset = 1'b1;
    MemWriteM = 1'b0; ALUOutM = 32'h0; WriteDataM = 32'h0; host_rd_en = 1'b0;

    // RAM store/load, including the last word and the first unmapped address
    vecs.push_back(mk(1, 32'h00, 32'h0000_0ABC, 0, 0, 32'h0, 1, 32'h0, 0));
    vecs.push_back(mk(1, 32'h10, 32'h1111_1111, 0, 0, 32'h0, 1, 32'h0, 0));
    vecs.push_back(mk(1, 32'h10, 32'hDEAD_BEEF, 0, 1, 32'h1111_1111, 1, 32'h0, 0));
    vecs.push_back(mk(0, 32'h13, 32'h0, 0, 1, 32'hDEAD_BEEF, 1, 32'h0, 0));
    vecs.push_back(mk(1, 32'hFC, 32'hCAFE_F00D, 0, 0, 32'h0, 1, 32'h0, 0));
    vecs.push_back(mk(0, 32'hFF, 32'h0, 0, 1, 32'hCAFE_F00D, 1, 32'h0, 0));
    vecs.push_back(mk(0, 32'h100, 32'h0, 0, 1, 32'h0, 1, 32'h0, 0));
    // FIFO basics
    vecs.push_back(mk(1, TX, 32'h1, 0, 1, 32'h1, 1, 32'h0, 0));
    vecs.push_back(mk(1, TX, 32'h2, 0, 1, 32'h0, 0, 32'h1, 0));
    vecs.push_back(mk(1, TX, 32'h3, 0, 1, 32'h0, 0, 32'h1, 0));
    vecs.push_back(mk(0, LVL, 32'h0, 0, 1, 32'h3, 0, 32'h1, 0));
    vecs.push_back(mk(0, LVL, 32'h0, 1, 1, 32'h3, 0, 32'h1, 0));
    vecs.push_back(mk(0, LVL, 32'h0, 1, 1, 32'h2, 0, 32'h2, 0));
    vecs.push_back(mk(0, LVL, 32'h0, 1, 1, 32'h1, 0, 32'h3, 0));
    vecs.push_back(mk(0, TX, 32'h0, 0, 1, 32'h1, 1, 32'h0, 0));
    // Pop while empty with a push: push wins, level becomes 1
    vecs.push_back(mk(1, TX, 32'hA, 1, 1, 32'h1, 1, 32'h0, 0));
    vecs.push_back(mk(0, LVL, 32'h0, 0, 1, 32'h1, 0, 32'hA, 0));
    vecs.push_back(mk(0, LVL, 32'h0, 1, 1, 32'h1, 0, 32'hA, 0));
    vecs.push_back(mk(0, TX, 32'h0, 0, 1, 32'h1, 1, 32'h0, 0));
    // Fill, overflow, push+pop while full, drain to the new tail, clear ovf
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, TX, 32'h10 + 32'(i), 0, 1, (i == 0) ? 32'h1 : 32'h0,
                        (i == 0), (i == 0) ? 32'h0 : 32'h10, 0));
    vecs.push_back(mk(0, TX, 32'h0, 0, 1, 32'h2, 0, 32'h10, 0));
    vecs.push_back(mk(1, TX, 32'h99, 0, 1, 32'h2, 0, 32'h10, 0));
    vecs.push_back(mk(0, TX, 32'h0, 0, 1, 32'h6, 0, 32'h10, 0));
    vecs.push_back(mk(1, TX, 32'h20, 1, 1, 32'h6, 0, 32'h10, 0));
    for (int i = 0; i < 7; i++)
      vecs.push_back(mk(0, LVL, 32'h0, 1, 1, 32'h8 - 32'(i), 0, 32'h11 + 32'(i), 0));
    vecs.push_back(mk(0, LVL, 32'h0, 0, 1, 32'h1, 0, 32'h20, 0));
    vecs.push_back(mk(1, CLR, 32'h1, 0, 1, 32'h0, 0, 32'h20, 0));
    vecs.push_back(mk(0, TX, 32'h0, 0, 1, 32'h0, 0, 32'h20, 0));
    vecs.push_back(mk(0, TX, 32'h0, 1, 1, 32'h0, 0, 32'h20, 0));
    vecs.push_back(mk(0, TX, 32'h0, 0, 1, 32'h1, 1, 32'h0, 0));
    // Error handling and selective clear
    vecs.push_back(mk(1, 32'h1000, 32'h55, 0, 1, 32'h0, 1, 32'h0, 0));
    vecs.push_back(mk(1, CYC, 32'h1234, 0, 0, 32'h0, 1, 32'h0, 1));
    vecs.push_back(mk(0, TX, 32'h0, 0, 1, 32'h9, 1, 32'h0, 1));
    vecs.push_back(mk(0, 32'h1000, 32'h0, 0, 1, 32'h0, 1, 32'h0, 1));
    vecs.push_back(mk(0, 32'h00, 32'h0, 0, 1, 32'h0000_0ABC, 1, 32'h0, 1));
    vecs.push_back(mk(0, 32'h10, 32'h0, 0, 1, 32'hDEAD_BEEF, 1, 32'h0, 1));
    vecs.push_back(mk(1, CLR, 32'h1, 0, 1, 32'h0, 1, 32'h0, 1));
    vecs.push_back(mk(0, TX, 32'h0, 0, 1, 32'h9, 1, 32'h0, 1));
    vecs.push_back(mk(1, CLR, 32'h2, 0, 1, 32'h0, 1, 32'h0, 1));
    vecs.push_back(mk(0, TX, 32'h0, 0, 1, 32'h1, 1, 32'h0, 0));
    vecs.push_back(mk(1, LVL, 32'h5, 0, 1, 32'h0, 1, 32'h0, 0));
    vecs.push_back(mk(0, TX, 32'h0, 0, 1, 32'h9, 1, 32'h0, 1));
    vecs.push_back(mk(1, CLR, 32'h2, 0, 1, 32'h0, 1, 32'h0, 1));
    vecs.push_back(mk(1, MB + 32'h10, 32'h7, 0, 1, 32'h0, 1, 32'h0, 0));
    vecs.push_back(mk(0, TX, 32'h0, 0, 1, 32'h9, 1, 32'h0, 1));
    vecs.push_back(mk(1, CLR, 32'h3, 0, 1, 32'h0, 1, 32'h0, 1));
    vecs.push_back(mk(0, TX, 32'h0, 0, 1, 32'h1, 1, 32'h0, 0));

    // Power-up reset state
    repeat (2) @(posedge clk);
    ALUOutM = TX; #1;
    check("rst_status", ReadDataM, 32'h1);
    check("rst_empty", {31'h0, host_empty}, 32'h1);
    check("rst_hrd", host_rd_data, 32'h0);
    check("rst_err", {31'h0, host_err}, 32'h0);

    // Counter counts clocks after reset release
    @(negedge clk); reset = 1'b0;
    repeat (5) @(posedge clk);
    #1; ALUOutM = CYC; #1;
    check("cycle_after_5", ReadDataM, 32'h5);

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].pop);
      if (vecs[i].chk) check($sformatf("v%0d rd", i), ReadDataM, vecs[i].exp_rd);
      check($sformatf("v%0d empty", i), {31'h0, host_empty}, {31'h0, vecs[i].exp_empty});
      check($sformatf("v%0d hrd", i), host_rd_data, vecs[i].exp_hrd);
      check($sformatf("v%0d err", i), {31'h0, host_err}, {31'h0, vecs[i].exp_err});
    end

    // Writes to CYCLE do not disturb the count
    drive(1, CYC, 32'h0000_FFFF, 0);
    check("cyc_wr_same", ReadDataM, exp_cyc);
    drive(0, CYC, 32'h0, 0);
    check("cyc_wr_next", ReadDataM, exp_cyc);
    drive(1, CLR, 32'h2, 0);

    // Build LEVEL=5 with ovf and err set, then reset asynchronously between edges
    drive(1, 32'h20, 32'h600D_F00D, 0);
    for (int i = 0; i < 8; i++) drive(1, TX, 32'h30 + 32'(i), 0);
    drive(1, TX, 32'hEE, 0);
    drive(1, 32'h2000, 32'h0, 0);
    repeat (3) drive(0, TX, 32'h0, 1);
    drive(0, LVL, 32'h0, 0);
    check("pre_rst_level", ReadDataM, 32'h5);
    ALUOutM = TX; #1;
    check("pre_rst_status", ReadDataM, 32'hC);
    #2; reset = 1'b1; #1;
    check("mid_rst_empty", {31'h0, host_empty}, 32'h1);
    check("mid_rst_hrd", host_rd_data, 32'h0);
    check("mid_rst_err", {31'h0, host_err}, 32'h0);
    check("mid_rst_status", ReadDataM, 32'h1);
    ALUOutM = CYC; #1;
    check("mid_rst_cycle", ReadDataM, 32'h0);
    ALUOutM = 32'h20; #1;
    check("mid_rst_ram", ReadDataM, 32'h600D_F00D);
    // Writes while reset is high are ignored
    MemWriteM = 1'b1; WriteDataM = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    check("rst_ram_wr_ignored", ReadDataM, 32'h600D_F00D);
    ALUOutM = TX; WriteDataM = 32'h77;
    @(posedge clk); #1;
    MemWriteM = 1'b0;
    check("rst_push_ignored", {31'h0, host_empty}, 32'h1);
    @(negedge clk); reset = 1'b0;
    drive(0, LVL, 32'h0, 0);
    check("post_rst_level", ReadDataM, 32'h0);

    // Counter wrap from a forced near-terminal value
    @(negedge clk);
    ALUOutM = CYC;
    force dut.cycle_r = 32'hFFFF_FFFE;
    #1 release dut.cycle_r;
    #1;
    check("cyc_forced", ReadDataM, 32'hFFFF_FFFE);
    @(posedge clk); #1;
    check("cyc_max", ReadDataM, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    check("cyc_wrap", ReadDataM, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
